// File: rtl/pixel_frame_writer.sv
// Assembles a raster-order pixel stream into a flat INPUT_H x INPUT_W frame bus.
// Latency: a pixel accepted at edge N is visible on X after edge N; frame_valid rises on the last pixel's edge.
// Backpressure: in_ready drops while a completed frame waits for frame_ready; one bubble cycle per frame.
module pixel_frame_writer #(
  parameter int INPUT_H   = 7,
  parameter int INPUT_W   = 7,
  parameter int PIXEL_BW  = 8,
  parameter int COORD_BIT = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PIXEL_BW-1:0]                   in_pixel,
  input  logic                                  in_sof,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [INPUT_H*INPUT_W*PIXEL_BW-1:0]   X,
  output logic                                  frame_valid,
  input  logic                                  frame_ready,
  output logic [COORD_BIT-1:0]                  cur_x,
  output logic [COORD_BIT-1:0]                  cur_y,
  output logic                                  sof_err
);

  localparam int NPIX  = INPUT_H * INPUT_W;
  localparam int IDX_W = $clog2(NPIX * PIXEL_BW);
  localparam logic [COORD_BIT-1:0] LAST_X = COORD_BIT'(INPUT_W - 1);
  localparam logic [COORD_BIT-1:0] LAST_Y = COORD_BIT'(INPUT_H - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic                 last_pix;
  logic [COORD_BIT-1:0] base_x;
  logic [COORD_BIT-1:0] base_y;
  logic [COORD_BIT-1:0] next_x;
  logic [COORD_BIT-1:0] next_y;
  int                   wr_idx;
  logic [IDX_W-1:0]     wr_lsb;

  // Write coordinate and the counter advance; an in_sof beat always lands on (0, 0).
  always_comb begin
    accept   = in_valid && in_ready && (state_q == FILL);
    base_x   = in_sof ? '0 : cur_x;
    base_y   = in_sof ? '0 : cur_y;
    last_pix = (base_x == LAST_X) && (base_y == LAST_Y);
    next_x   = base_x + COORD_BIT'(1);
    next_y   = base_y;
    if (base_x == LAST_X) begin
      next_x = '0;
      next_y = last_pix ? '0 : base_y + COORD_BIT'(1);
    end
    wr_idx = int'(base_y) * INPUT_W + int'(base_x);
    wr_lsb = IDX_W'(wr_idx * PIXEL_BW);
  end

  // Next-state: fill until the last coordinate is written, then hold until the consumer takes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept && last_pix) state_d = FULL;
      FULL: if (frame_valid && frame_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State, registered handshakes, coordinate counters and the restart pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      sof_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready    <= (state_d == FILL);
      frame_valid <= (state_d == FULL);
      sof_err     <= accept && in_sof && ((cur_x != '0) || (cur_y != '0));
      if (accept) begin
        cur_x <= next_x;
        cur_y <= next_y;
      end
    end
  end

  // Frame buffer: only accepted pixels write; contents persist across frames until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X <= '0;
    end else if (accept) begin
      X[wr_lsb +: PIXEL_BW] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer: randomized streams against a frame-array reference model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Each scenario task checks its own results inline.
module tb_pixel_frame_writer;
  localparam int H  = 7;
  localparam int W  = 7;
  localparam int BW = 8;
  localparam int N  = H * W;

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   in_pixel;
  logic            in_sof;
  logic            in_valid;
  logic            in_ready;
  logic [N*BW-1:0] X;
  logic            frame_valid;
  logic            frame_ready;
  logic [2:0]      cur_x;
  logic [2:0]      cur_y;
  logic            sof_err;

  pixel_frame_writer #(.INPUT_H(H), .INPUT_W(W), .PIXEL_BW(BW), .COORD_BIT(3)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .X(X), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .cur_x(cur_x), .cur_y(cur_y), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame as a pixel array indexed by raster position.
  logic [BW-1:0]   frame [N];
  int              m_pos;
  bit              m_ready, m_fvalid, m_err, m_boot;
  logic [N*BW-1:0] basic_x;

  function automatic logic [N*BW-1:0] model_x();
    logic [N*BW-1:0] v;
    for (int i = 0; i < N; i++) v[i*BW +: BW] = frame[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) frame[i] = '0;
    m_pos = 0; m_ready = 0; m_fvalid = 0; m_err = 0; m_boot = 1;
  endtask

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    bit acc, hs;
    int p;
    acc = in_valid && m_ready && !rst;
    hs  = m_fvalid && frame_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_err = 0;
      if (m_boot) begin
        m_boot = 0; m_ready = 1;
      end else if (acc) begin
        p = in_sof ? 0 : m_pos;
        m_err = in_sof && (m_pos != 0);
        frame[p] = in_pixel;
        m_pos = p + 1;
        if (m_pos == N) begin
          m_pos = 0; m_fvalid = 1; m_ready = 0;
        end
      end else if (hs) begin
        m_fvalid = 0; m_ready = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_sof = 0; in_pixel = '0; frame_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (X !== '0) begin errors++; $display("FAIL reset_x: got %h expected 0", X); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %b expected 0", frame_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    checks++; if ({cur_y, cur_x} !== 6'd0) begin errors++; $display("FAIL reset_cur: got y=%0d x=%0d expected 0,0", cur_y, cur_x); end
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err: got %b expected 0", sof_err); end
    rst = 0;
    tick();
    checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL ready_after_release: got %b expected %b", in_ready, m_ready); end
  endtask

  task automatic test_basic_fill();
    for (int n = 0; n < N; n++) begin
      in_valid = 1; in_sof = (n == 0); in_pixel = BW'(n);
      tick();
      checks++;
      if (cur_x !== 3'(m_pos % W) || cur_y !== 3'(m_pos / W)) begin
        errors++; $display("FAIL fill_cur: got y=%0d x=%0d expected %0d,%0d", cur_y, cur_x, m_pos / W, m_pos % W);
      end
    end
    in_valid = 0; in_sof = 0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fill_fvalid: got %b expected 1", frame_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", in_ready); end
    checks++; if (X[7:0] !== 8'd0) begin errors++; $display("FAIL fill_px00: got %0d expected 0", X[7:0]); end
    checks++; if (X[(3*7+4+1)*8-1 -: 8] !== 8'd25) begin errors++; $display("FAIL fill_px34: got %0d expected 25", X[(3*7+4+1)*8-1 -: 8]); end
    checks++; if (X[391:384] !== 8'd48) begin errors++; $display("FAIL fill_px66: got %0d expected 48", X[391:384]); end
    checks++; if (X !== model_x()) begin errors++; $display("FAIL fill_x: got %h expected %h", X, model_x()); end
    basic_x = model_x();
  endtask

  task automatic test_full_hold();
    logic [N*BW-1:0] hold;
    hold = model_x();
    frame_ready = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1; in_pixel = BW'($urandom); in_sof = 1'($urandom % 2);
      tick();
      checks++;
      if (X !== hold || in_ready !== 1'b0 || frame_valid !== 1'b1) begin
        errors++; $display("FAIL full_hold: cycle %0d ready=%b fvalid=%b x=%h expected ready=0 fvalid=1 x=%h", i, in_ready, frame_valid, X, hold);
      end
    end
    in_valid = 0; in_sof = 0;
  endtask

  task automatic test_back_to_back();
    int n, cyc, zeros;
    bit acc_pred;
    frame_ready = 1; in_valid = 0;
    tick();
    checks++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL handoff: got fvalid=%b ready=%b expected 0,1", frame_valid, in_ready); end
    n = 0; cyc = 0; zeros = 0;
    while (n < 2*N && cyc < 300) begin
      in_valid = 1; in_sof = (n == 0 || n == N);
      in_pixel = (n < N) ? BW'(n) : BW'(100 + n - N);
      acc_pred = m_ready;
      tick();
      cyc++;
      if (acc_pred) n++;
      checks++;
      if (in_ready !== m_ready || frame_valid !== m_fvalid) begin
        errors++; $display("FAIL b2b_hs: cycle %0d ready=%b fvalid=%b expected %b,%b", cyc, in_ready, frame_valid, m_ready, m_fvalid);
      end
      if (n > 0 && n < 2*N && in_ready === 1'b0) zeros++;
    end
    in_valid = 0; in_sof = 0; frame_ready = 0;
    checks++; if (n != 2*N) begin errors++; $display("FAIL b2b_timeout: accepted %0d expected %0d", n, 2*N); end
    checks++; if (zeros != 1) begin errors++; $display("FAIL b2b_bubble: got %0d stall cycles expected 1", zeros); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fvalid: got %b expected 1", frame_valid); end
    checks++; if (X[7:0] !== 8'd100) begin errors++; $display("FAIL b2b_px00: got %0d expected 100", X[7:0]); end
    checks++; if (X !== model_x()) begin errors++; $display("FAIL b2b_x: got %h expected %h", X, model_x()); end
  endtask

  task automatic test_gapped();
    int n, cyc;
    bit acc_pred;
    frame_ready = 1;
    n = 0; cyc = 0;
    while (n < N && cyc < 200) begin
      in_valid = 1'(cyc % 2); in_sof = (n == 0); in_pixel = BW'(n);
      acc_pred = in_valid && m_ready;
      tick();
      cyc++;
      if (acc_pred) n++;
      checks++;
      if (cur_x !== 3'(m_pos % W) || cur_y !== 3'(m_pos / W) || frame_valid !== m_fvalid) begin
        errors++; $display("FAIL gap_cur: cycle %0d y=%0d x=%0d fvalid=%b expected %0d,%0d,%b", cyc, cur_y, cur_x, frame_valid, m_pos / W, m_pos % W, m_fvalid);
      end
    end
    in_valid = 0; in_sof = 0; frame_ready = 0;
    checks++; if (n != N) begin errors++; $display("FAIL gap_timeout: accepted %0d expected %0d", n, N); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL gap_fvalid: got %b expected 1", frame_valid); end
    checks++; if (X !== basic_x) begin errors++; $display("FAIL gap_x: got %h expected %h", X, basic_x); end
  endtask

  task automatic test_early_restart();
    frame_ready = 1; in_valid = 0;
    tick();
    frame_ready = 0;
    for (int n = 0; n < 10; n++) begin
      in_valid = 1; in_sof = (n == 0); in_pixel = BW'($urandom);
      tick();
    end
    in_sof = 1; in_pixel = 8'hAA;
    tick();
    checks++; if (sof_err !== m_err || sof_err !== 1'b1) begin errors++; $display("FAIL restart_err: got %b expected 1", sof_err); end
    checks++; if (X[7:0] !== 8'hAA) begin errors++; $display("FAIL restart_px00: got %h expected aa", X[7:0]); end
    checks++; if (cur_x !== 3'd1 || cur_y !== 3'd0) begin errors++; $display("FAIL restart_cur: got y=%0d x=%0d expected 0,1", cur_y, cur_x); end
    in_valid = 0; in_sof = 0;
    tick();
    checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL restart_pulse: got %b expected 0", sof_err); end
    for (int n = 0; n < N - 1; n++) begin
      in_valid = 1; in_pixel = BW'($urandom);
      tick();
      checks++;
      if (frame_valid !== m_fvalid || sof_err !== 1'b0) begin
        errors++; $display("FAIL restart_fill: pixel %0d fvalid=%b err=%b expected %b,0", n, frame_valid, sof_err, m_fvalid);
      end
    end
    in_valid = 0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL restart_fvalid: got %b expected 1", frame_valid); end
    checks++; if (X !== model_x()) begin errors++; $display("FAIL restart_x: got %h expected %h", X, model_x()); end
  endtask

  task automatic test_reset_mid();
    frame_ready = 1; in_valid = 0;
    tick();
    frame_ready = 0;
    for (int n = 0; n < 20; n++) begin
      in_valid = 1; in_sof = (n == 0); in_pixel = BW'($urandom);
      tick();
    end
    in_valid = 0; in_sof = 0;
    #2; rst = 1; model_reset();
    #1;
    checks++;
    if (X !== '0 || frame_valid !== 1'b0 || in_ready !== 1'b0 || {cur_y, cur_x} !== 6'd0) begin
      errors++; $display("FAIL midreset: ready=%b fvalid=%b y=%0d x=%0d x_nonzero=%b expected all 0", in_ready, frame_valid, cur_y, cur_x, |X);
    end
    #2; rst = 0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
    in_valid = 1; in_sof = 0; in_pixel = BW'($urandom);
    tick();
    checks++; if (X !== model_x() || cur_x !== 3'd1) begin errors++; $display("FAIL midreset_first: x=%h cur_x=%0d expected %h,1", X, cur_x, model_x()); end
    for (int n = 0; n < N - 1; n++) begin
      in_pixel = BW'($urandom);
      tick();
    end
    in_valid = 0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL midreset_fvalid: got %b expected 1", frame_valid); end
    checks++; if (X !== model_x()) begin errors++; $display("FAIL midreset_x: got %h expected %h", X, model_x()); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_full_hold();
    test_back_to_back();
    test_gapped();
    test_early_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
